// File: rtl/deserializador_fifo.sv
// deserializador_fifo: serial-to-parallel word assembler feeding a small word
// FIFO, drained by a four-phase (data_ready / ack_in) consumer handshake.
//
// Ports:
//   clk_100KHz  in   single clock, all state updates on the rising edge
//   reset       in   synchronous active-high reset
//   data_in     in   serial data bit, sampled when write_in=1
//   write_in    in   qualifies data_in, one bit per cycle
//   ack_in      in   four-phase consumer acknowledge
//   data_out    out  presented word (0 when nothing is presented)
//   data_ready  out  data_out holds a valid word
//   status_out  out  FIFO full; source must hold write_in low
//   fifo_count  out  complete words stored, including the presented one
//   overflow    out  sticky: a bit was offered while the FIFO was full
module deserializador_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk_100KHz,
    input  logic                     reset,
    input  logic                     data_in,
    input  logic                     write_in,
    input  logic                     ack_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_ready,
    output logic                     status_out,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PRESENT = 2'd1,
        ST_H_ACK   = 2'd2
    } state_t;

    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bit_cnt;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    state_t           r_state;

    logic             w_accept;
    logic             w_push;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]    w_count_nxt;
    state_t           w_state_nxt;
    logic             w_pop;
    logic             w_load;
    logic             w_clear;

    // Bits offered while full are dropped; the completing bit pushes a word.
    assign w_accept = write_in & ~status_out;
    assign w_push   = w_accept & (r_bit_cnt == BW'(WIDTH - 1));

    // Shifted value including the incoming bit; on the last bit this is the word.
    assign w_shift_nxt = MSB_FIRST ? {r_shift[WIDTH-2:0], data_in}
                                   : {data_in, r_shift[WIDTH-1:1]};

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        w_count_nxt = fifo_count;
        if (w_push && !w_pop) begin
            w_count_nxt = fifo_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = fifo_count - CW'(1);
        end
    end

    // Serial assembly, pointers, count, full and overflow flags.
    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            fifo_count <= '0;
            status_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift   <= w_shift_nxt;
                r_bit_cnt <= w_push ? '0 : r_bit_cnt + BW'(1);
            end
            if (write_in && status_out) begin
                overflow <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            fifo_count <= w_count_nxt;
            status_out <= (w_count_nxt == CW'(DEPTH));
        end
    end

    // Word storage; contents are only read when fifo_count says they are valid.
    always_ff @(posedge clk_100KHz) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_shift_nxt;
        end
    end

    // Consumer FSM state register.
    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Consumer FSM next state and handshake actions.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (fifo_count != '0) begin
                    w_state_nxt = ST_PRESENT;
                    w_load      = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (ack_in) begin
                    w_state_nxt = ST_H_ACK;
                    w_pop       = 1'b1;
                    w_clear     = 1'b1;
                end
            end
            ST_H_ACK: begin
                if (!ack_in) begin
                    if (fifo_count != '0) begin
                        w_state_nxt = ST_PRESENT;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Presented word is captured on entry to PRESENT and held until popped.
    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            data_out   <= '0;
            data_ready <= 1'b0;
        end else if (w_load) begin
            data_out   <= r_mem[r_rd_ptr];
            data_ready <= 1'b1;
        end else if (w_clear) begin
            data_out   <= '0;
            data_ready <= 1'b0;
        end
    end

endmodule

// File: tb/tb_deserializador_fifo.sv
// Bench for deserializador_fifo: an MSB-first and an LSB-first instance share
// the same serial stimulus; each has its own expected-word queue drained by a
// monitor on the rising edge of data_ready.
`timescale 1ns/1ps
module tb_deserializador_fifo;

    logic       clk;
    logic       reset;
    logic       data_in;
    logic       write_in;
    logic       ack_in;

    logic [7:0] dout_m, dout_l;
    logic       rdy_m, rdy_l;
    logic       st_m, st_l;
    logic [2:0] cnt_m, cnt_l;
    logic       ovf_m, ovf_l;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    deserializador_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk_100KHz (clk),
        .reset      (reset),
        .data_in    (data_in),
        .write_in   (write_in),
        .ack_in     (ack_in),
        .data_out   (dout_m),
        .data_ready (rdy_m),
        .status_out (st_m),
        .fifo_count (cnt_m),
        .overflow   (ovf_m)
    );

    deserializador_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk_100KHz (clk),
        .reset      (reset),
        .data_in    (data_in),
        .write_in   (write_in),
        .ack_in     (ack_in),
        .data_out   (dout_l),
        .data_ready (rdy_l),
        .status_out (st_l),
        .fifo_count (cnt_l),
        .overflow   (ovf_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Monitors: compare the presented word each time data_ready rises.
    logic prev_m = 1'b0;
    logic prev_l = 1'b0;
    always @(negedge clk) begin
        logic [7:0] e;
        if (rdy_m && !prev_m) begin
            if (q_m.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL msb_unexpected_word: got 0x%0h expected none", dout_m);
            end else begin
                e = q_m.pop_front();
                check("msb_word", 32'(dout_m), 32'(e));
            end
        end
        if (rdy_l && !prev_l) begin
            if (q_l.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL lsb_unexpected_word: got 0x%0h expected none", dout_l);
            end else begin
                e = q_l.pop_front();
                check("lsb_word", 32'(dout_l), 32'(e));
            end
        end
        prev_m = rdy_m;
        prev_l = rdy_l;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        data_in  = b;
        write_in = 1'b1;
        tick();
        write_in = 1'b0;
    endtask

    // seq[7] is the first serial bit; MSB instance sees seq, LSB sees rev8(seq).
    task automatic send_word(input logic [7:0] seq, input bit expect_push);
        if (expect_push) begin
            q_m.push_back(seq);
            q_l.push_back(rev8(seq));
        end
        for (int i = 7; i >= 0; i--) send_bit(seq[i]);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!rdy_m && n < 30) begin
            tick();
            n++;
        end
        if (!rdy_m) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: got data_ready=0 expected 1", name);
        end
    endtask

    task automatic do_ack(input string name);
        wait_ready(name);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w77;
        reset = 1'b1; data_in = 1'b0; write_in = 1'b0; ack_in = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_data_out",   32'(dout_m), 32'h0);
        check("rst_data_ready", 32'(rdy_m),  32'h0);
        check("rst_status",     32'(st_m),   32'h0);
        check("rst_count",      32'(cnt_m),  32'h0);
        check("rst_overflow",   32'(ovf_m),  32'h0);

        // Basic word and EMPTY-state latency.
        send_word(8'hA5, 1);
        check("a5_count_after_last", 32'(cnt_m), 32'd1);
        check("a5_ready_same_edge",  32'(rdy_m), 32'd0);
        tick();
        check("a5_ready_next_edge",  32'(rdy_m), 32'd1);
        do_ack("a5");
        check("a5_ready_after_ack",  32'(rdy_m), 32'd0);
        check("a5_count_after_ack",  32'(cnt_m), 32'd0);

        // Asymmetric word: MSB instance 0x80, LSB instance 0x01.
        send_word(8'h80, 1);
        do_ack("w80");

        // Fill to full, overflow on a fifth word, then drain in order.
        send_word(8'h11, 1);
        send_word(8'h22, 1);
        send_word(8'h33, 1);
        check("full_ovf_before", 32'(ovf_m), 32'd0);
        send_word(8'h44, 1);
        check("full_status", 32'(st_m),  32'd1);
        check("full_count",  32'(cnt_m), 32'd4);
        send_word(8'h55, 0);
        check("ovf_set",       32'(ovf_m), 32'd1);
        check("ovf_set_lsb",   32'(ovf_l), 32'd1);
        check("ovf_count",     32'(cnt_m), 32'd4);
        do_ack("d1");
        do_ack("d2");
        do_ack("d3");
        do_ack("d4");
        tick();
        check("drain_count",   32'(cnt_m), 32'd0);
        check("drain_status",  32'(st_m),  32'd0);
        check("ovf_sticky",    32'(ovf_m), 32'd1);

        // Push and pop on the same edge.
        send_word(8'h66, 1);
        wait_ready("w66");
        check("coinc_count_before", 32'(cnt_m), 32'd1);
        w77 = 8'h77;
        q_m.push_back(w77);
        q_l.push_back(rev8(w77));
        for (int i = 7; i >= 1; i--) send_bit(w77[i]);
        data_in = w77[0]; write_in = 1'b1; ack_in = 1'b1;
        tick();
        write_in = 1'b0; ack_in = 1'b0;
        check("coinc_count_after", 32'(cnt_m), 32'd1);
        check("coinc_ready_low",   32'(rdy_m), 32'd0);
        tick();
        check("coinc_next_ready",  32'(rdy_m), 32'd1);
        do_ack("w77");
        check("coinc_drained", 32'(cnt_m), 32'd0);

        // Reset mid-word with two words stored.
        send_word(8'h12, 1);
        send_word(8'h34, 1);
        wait_ready("w12");
        for (int i = 7; i >= 3; i--) send_bit(i[0]);
        check("pre_rst_count", 32'(cnt_m), 32'd2);
        q_m.delete();
        q_l.delete();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_data_out", 32'(dout_m), 32'h0);
        check("mid_rst_ready",    32'(rdy_m),  32'h0);
        check("mid_rst_count",    32'(cnt_m),  32'h0);
        check("mid_rst_status",   32'(st_m),   32'h0);
        check("mid_rst_overflow", 32'(ovf_m),  32'h0);
        send_word(8'h9C, 1);
        wait_ready("w9c");
        check("post_rst_count", 32'(cnt_m), 32'd1);
        do_ack("w9c");
        tick(); tick();
        check("post_rst_ready", 32'(rdy_m), 32'd0);
        check("post_rst_empty", 32'(cnt_m), 32'd0);

        // Ack while EMPTY is ignored.
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        check("empty_ack_ready", 32'(rdy_m), 32'd0);
        check("empty_ack_count", 32'(cnt_m), 32'd0);
        send_word(8'hC3, 1);
        do_ack("wc3");
        check("c3_drained", 32'(cnt_m), 32'd0);

        tick(); tick();
        check("msb_queue_empty", 32'(q_m.size()), 32'd0);
        check("lsb_queue_empty", 32'(q_l.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
